if_stage: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the decode stage.
- Owns the PC register, drives the instruction-memory read address, and registers the {PC+4, instruction} pair into the 64-bit IF_ID pipeline register that decode consumes.
- Applies the redirect and stall controls that decode produces: Z, J, JR, interrupt, exception and PC_IF_ID_Write.
- PC[31] is the supervisor-mode bit.

---
 rtl/if_stage.sv | 103 ++++++++++
 tb/tb_if_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, imem address, IF_ID pipeline register and redirect/stall handling.
// Optional performance counters (fetch_cnt, flush_cnt) are built when IF_PERF_CNT_EN is defined.
module if_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h80000000,
  parameter logic [31:0] INTR_VECTOR  = 32'h80000004,
  parameter logic [31:0] EXCP_VECTOR  = 32'h80000008,
  parameter logic [31:0] NOP_WORD     = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PC_IF_ID_Write,
  input  logic        Z,
  input  logic        J,
  input  logic        JR,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  input  logic        interrupt,
  input  logic        exception,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] PC,
  output logic [63:0] IF_ID,
  output logic [31:0] fetch_cnt,
  output logic [31:0] flush_cnt
);

  logic [31:0] pc_reg, pc_next;
  logic [63:0] if_id_reg, if_id_next;
  logic [31:0] pc_plus4;
  logic        do_fetch;
  logic        do_flush;

  // Bit 31 is the supervisor bit and never receives a carry from the low bits.
  assign pc_plus4  = {pc_reg[31], pc_reg[30:0] + 31'd4};
  assign imem_addr = {1'b0, pc_reg[30:0]};
  assign PC        = pc_reg;
  assign IF_ID     = if_id_reg;

  always_comb begin
    pc_next    = pc_reg;
    if_id_next = if_id_reg;
    do_fetch   = 1'b0;
    do_flush   = 1'b1;
    if (exception) begin
      pc_next    = EXCP_VECTOR;
      if_id_next = {pc_plus4, NOP_WORD};
    end else if (interrupt) begin
      pc_next    = INTR_VECTOR;
      if_id_next = {pc_plus4, NOP_WORD};
    end else if (!PC_IF_ID_Write) begin
      do_flush   = 1'b0;
    end else if (JR) begin
      // jr may drop to user mode but never raise the supervisor bit
      pc_next    = {pc_reg[31] & jr_target[31], jr_target[30:0]};
      if_id_next = {pc_plus4, NOP_WORD};
    end else if (J) begin
      pc_next    = {pc_reg[31], jump_target[30:0]};
      if_id_next = {pc_plus4, NOP_WORD};
    end else if (Z) begin
      pc_next    = {pc_reg[31], branch_target[30:0]};
      if_id_next = {pc_plus4, NOP_WORD};
    end else begin
      pc_next    = pc_plus4;
      if_id_next = {pc_plus4, imem_rdata};
      do_fetch   = 1'b1;
      do_flush   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg    <= RESET_VECTOR;
      if_id_reg <= 64'h0;
    end else begin
      pc_reg    <= pc_next;
      if_id_reg <= if_id_next;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_reg, flush_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_reg <= 32'h0;
      flush_cnt_reg <= 32'h0;
    end else begin
      if (do_fetch) fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
      if (do_flush) flush_cnt_reg <= flush_cnt_reg + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`else
  logic unused_cnt;
  assign unused_cnt = do_fetch ^ do_flush;
  assign fetch_cnt  = 32'h0;
  assign flush_cnt  = 32'h0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage; counter expectations follow IF_PERF_CNT_EN.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        PC_IF_ID_Write;
  logic        Z, J, JR;
  logic [31:0] branch_target, jump_target, jr_target;
  logic        interrupt, exception;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic [31:0] PC;
  logic [63:0] IF_ID;
  logic [31:0] fetch_cnt, flush_cnt;

  int tests = 0;
  int failed = 0;
  int exp_fetch = 0;
  int exp_flush = 0;
  logic [63:0] held_if_id;

  if_stage dut (
    .clk(clk), .reset(reset), .PC_IF_ID_Write(PC_IF_ID_Write),
    .Z(Z), .J(J), .JR(JR),
    .branch_target(branch_target), .jump_target(jump_target), .jr_target(jr_target),
    .interrupt(interrupt), .exception(exception),
    .imem_rdata(imem_rdata), .imem_addr(imem_addr),
    .PC(PC), .IF_ID(IF_ID), .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] cnt_exp(input int n);
`ifdef IF_PERF_CNT_EN
    return n;
`else
    return 32'h0;
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    PC_IF_ID_Write = 1'b1;
    Z = 1'b0; J = 1'b0; JR = 1'b0;
    interrupt = 1'b0; exception = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle_inputs();
    branch_target = 32'h0; jump_target = 32'h0; jr_target = 32'h0;
    imem_rdata = 32'h20080001;
    tick(); tick();
    exp_fetch = 0; exp_flush = 0;
    tests++; if (PC !== 32'h80000000) begin failed++; $display("FAIL reset_pc: got %h expected %h", PC, 32'h80000000); end
    tests++; if (IF_ID !== 64'h0) begin failed++; $display("FAIL reset_if_id: got %h expected %h", IF_ID, 64'h0); end
    tests++; if (fetch_cnt !== cnt_exp(0) || flush_cnt !== cnt_exp(0)) begin failed++; $display("FAIL reset_cnt: got %h/%h expected 0/0", fetch_cnt, flush_cnt); end
    $display("[TB] reset: PC=%h IF_ID=%h", PC, IF_ID);
    reset = 1'b0;
  endtask

  task automatic test_sequential;
    tests++; if (imem_addr !== 32'h00000000) begin failed++; $display("FAIL seq_addr0: got %h expected %h", imem_addr, 32'h0); end
    tick(); exp_fetch++;
    tests++; if (PC !== 32'h80000004) begin failed++; $display("FAIL seq_pc1: got %h expected %h", PC, 32'h80000004); end
    tests++; if (IF_ID !== 64'h80000004_20080001) begin failed++; $display("FAIL seq_if_id1: got %h expected %h", IF_ID, 64'h80000004_20080001); end
    tests++; if (imem_addr !== 32'h00000004) begin failed++; $display("FAIL seq_addr1: got %h expected %h", imem_addr, 32'h4); end
    tick(); exp_fetch++;
    tests++; if (PC !== 32'h80000008) begin failed++; $display("FAIL seq_pc2: got %h expected %h", PC, 32'h80000008); end
    tick(); exp_fetch++;
    tests++; if (PC !== 32'h8000000C) begin failed++; $display("FAIL seq_pc3: got %h expected %h", PC, 32'h8000000C); end
    tests++; if (fetch_cnt !== cnt_exp(exp_fetch)) begin failed++; $display("FAIL seq_fetch_cnt: got %0d expected %0d", fetch_cnt, cnt_exp(exp_fetch)); end
    $display("[TB] sequential: PC=%h IF_ID=%h", PC, IF_ID);
  endtask

  task automatic test_branch;
    tick(); exp_fetch++;
    tests++; if (PC !== 32'h80000010) begin failed++; $display("FAIL br_pre_pc: got %h expected %h", PC, 32'h80000010); end
    Z = 1'b1; branch_target = 32'h80000040;
    tick(); exp_flush++;
    Z = 1'b0;
    tests++; if (PC !== 32'h80000040) begin failed++; $display("FAIL br_pc: got %h expected %h", PC, 32'h80000040); end
    tests++; if (IF_ID !== 64'h80000014_00000000) begin failed++; $display("FAIL br_if_id: got %h expected %h", IF_ID, 64'h80000014_00000000); end
    tests++; if (flush_cnt !== cnt_exp(exp_flush)) begin failed++; $display("FAIL br_flush_cnt: got %0d expected %0d", flush_cnt, cnt_exp(exp_flush)); end
    tick(); exp_fetch++;
    tests++; if (IF_ID !== 64'h80000044_20080001) begin failed++; $display("FAIL br_target_fetch: got %h expected %h", IF_ID, 64'h80000044_20080001); end
    $display("[TB] branch: PC=%h IF_ID=%h", PC, IF_ID);
  endtask

  task automatic test_stall;
    held_if_id = 64'h80000044_20080001;
    PC_IF_ID_Write = 1'b0; J = 1'b1; jump_target = 32'h00400000;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++; if (PC !== 32'h80000044 || IF_ID !== held_if_id) begin failed++; $display("FAIL stall_hold%0d: got %h/%h expected %h/%h", i, PC, IF_ID, 32'h80000044, held_if_id); end
    end
    PC_IF_ID_Write = 1'b1;
    tick(); exp_flush++;
    J = 1'b0;
    tests++; if (PC !== 32'h80400000) begin failed++; $display("FAIL stall_jump_pc: got %h expected %h", PC, 32'h80400000); end
    tests++; if (IF_ID !== 64'h80000048_00000000) begin failed++; $display("FAIL stall_jump_if_id: got %h expected %h", IF_ID, 64'h80000048_00000000); end
    $display("[TB] stall: PC=%h IF_ID=%h", PC, IF_ID);
  endtask

  task automatic test_jr;
    J = 1'b1; jump_target = 32'h00000100;
    tick(); exp_flush++;
    J = 1'b0;
    tests++; if (PC !== 32'h80000100) begin failed++; $display("FAIL jr_setup_pc: got %h expected %h", PC, 32'h80000100); end
    JR = 1'b1; jr_target = 32'h00400020;
    tick(); exp_flush++;
    tests++; if (PC !== 32'h00400020) begin failed++; $display("FAIL jr_user_pc: got %h expected %h", PC, 32'h00400020); end
    tests++; if (IF_ID !== 64'h80000104_00000000) begin failed++; $display("FAIL jr_if_id: got %h expected %h", IF_ID, 64'h80000104_00000000); end
    jr_target = 32'h80000000;
    tick(); exp_flush++;
    JR = 1'b0;
    tests++; if (PC !== 32'h00000000) begin failed++; $display("FAIL jr_no_super: got %h expected %h", PC, 32'h0); end
    tests++; if (flush_cnt !== cnt_exp(exp_flush)) begin failed++; $display("FAIL jr_flush_cnt: got %0d expected %0d", flush_cnt, cnt_exp(exp_flush)); end
    $display("[TB] jr: PC=%h IF_ID=%h", PC, IF_ID);
  endtask

  task automatic test_priority;
    JR = 1'b1; jr_target = 32'h00400100;
    tick(); exp_flush++;
    exception = 1'b1; interrupt = 1'b1; PC_IF_ID_Write = 1'b0;
    tick(); exp_flush++;
    tests++; if (PC !== 32'h80000008) begin failed++; $display("FAIL prio_excp_pc: got %h expected %h", PC, 32'h80000008); end
    tests++; if (IF_ID !== 64'h00400104_00000000) begin failed++; $display("FAIL prio_excp_if_id: got %h expected %h", IF_ID, 64'h00400104_00000000); end
    exception = 1'b0; interrupt = 1'b0; PC_IF_ID_Write = 1'b1;
    tick(); exp_flush++;
    JR = 1'b0;
    tests++; if (PC !== 32'h00400100) begin failed++; $display("FAIL prio_setup_pc: got %h expected %h", PC, 32'h00400100); end
    interrupt = 1'b1; PC_IF_ID_Write = 1'b0;
    tick(); exp_flush++;
    interrupt = 1'b0; PC_IF_ID_Write = 1'b1;
    tests++; if (PC !== 32'h80000004) begin failed++; $display("FAIL prio_intr_pc: got %h expected %h", PC, 32'h80000004); end
    tests++; if (IF_ID !== 64'h00400104_00000000) begin failed++; $display("FAIL prio_intr_if_id: got %h expected %h", IF_ID, 64'h00400104_00000000); end
    $display("[TB] priority: PC=%h IF_ID=%h", PC, IF_ID);
  endtask

  task automatic test_wrap;
    JR = 1'b1; jr_target = 32'h7FFFFFFC;
    tick(); exp_flush++;
    JR = 1'b0;
    tests++; if (PC !== 32'h7FFFFFFC) begin failed++; $display("FAIL wrap_setup_user: got %h expected %h", PC, 32'h7FFFFFFC); end
    tick(); exp_fetch++;
    tests++; if (PC !== 32'h00000000 || IF_ID !== 64'h00000000_20080001) begin failed++; $display("FAIL wrap_user: got %h/%h expected %h/%h", PC, IF_ID, 32'h0, 64'h00000000_20080001); end
    interrupt = 1'b1;
    tick(); exp_flush++;
    interrupt = 1'b0;
    J = 1'b1; jump_target = 32'h7FFFFFFC;
    tick(); exp_flush++;
    J = 1'b0;
    tests++; if (PC !== 32'hFFFFFFFC) begin failed++; $display("FAIL wrap_setup_super: got %h expected %h", PC, 32'hFFFFFFFC); end
    tick(); exp_fetch++;
    tests++; if (PC !== 32'h80000000 || IF_ID !== 64'h80000000_20080001) begin failed++; $display("FAIL wrap_super: got %h/%h expected %h/%h", PC, IF_ID, 32'h80000000, 64'h80000000_20080001); end
    tests++; if (fetch_cnt !== cnt_exp(exp_fetch) || flush_cnt !== cnt_exp(exp_flush)) begin failed++; $display("FAIL wrap_cnt: got %0d/%0d expected %0d/%0d", fetch_cnt, flush_cnt, cnt_exp(exp_fetch), cnt_exp(exp_flush)); end
    $display("[TB] wrap: PC=%h IF_ID=%h", PC, IF_ID);
  endtask

  task automatic test_reset_mid;
    JR = 1'b1; jr_target = 32'h00400200;
    tick(); exp_flush++;
    JR = 1'b0;
    tests++; if (PC !== 32'h00400200) begin failed++; $display("FAIL rmid_setup_pc: got %h expected %h", PC, 32'h00400200); end
    reset = 1'b1; Z = 1'b1; branch_target = 32'h00000040;
    tick();
    reset = 1'b0; Z = 1'b0;
    exp_fetch = 0; exp_flush = 0;
    tests++; if (PC !== 32'h80000000 || IF_ID !== 64'h0) begin failed++; $display("FAIL rmid_state: got %h/%h expected %h/%h", PC, IF_ID, 32'h80000000, 64'h0); end
    tests++; if (fetch_cnt !== 32'h0 || flush_cnt !== 32'h0) begin failed++; $display("FAIL rmid_cnt: got %h/%h expected 0/0", fetch_cnt, flush_cnt); end
    $display("[TB] reset_mid: PC=%h IF_ID=%h", PC, IF_ID);
  endtask

  task automatic test_back_to_back;
    J = 1'b1; jump_target = 32'h00000200;
    Z = 1'b1; branch_target = 32'h00000300;
    tick(); exp_flush++;
    J = 1'b0; Z = 1'b0;
    tests++; if (PC !== 32'h80000200) begin failed++; $display("FAIL b2b_j_over_z: got %h expected %h", PC, 32'h80000200); end
    Z = 1'b1; branch_target = 32'h00000400;
    tick(); exp_flush++;
    Z = 1'b0;
    tests++; if (PC !== 32'h80000400 || IF_ID !== 64'h80000204_00000000) begin failed++; $display("FAIL b2b_branch: got %h/%h expected %h/%h", PC, IF_ID, 32'h80000400, 64'h80000204_00000000); end
    tests++; if (flush_cnt !== cnt_exp(exp_flush)) begin failed++; $display("FAIL b2b_flush_cnt: got %0d expected %0d", flush_cnt, cnt_exp(exp_flush)); end
    $display("[TB] back_to_back: PC=%h IF_ID=%h", PC, IF_ID);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_jr();
    test_priority();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
